// File: rtl/addsub_pkg.sv
// Package: addsub_pkg
// Purpose : Shared operation encodings and decode helpers for the pipelined
//           adder/subtractor (addsub_pipe) and its carry-lookahead slices.
// Contents:
//   OP_ADD / OP_ADC / OP_SUB / OP_SBB  2-bit operation codes
//   is_sub(op)   1 when operand B must be inverted (SUB, SBB)
//   uses_cin(op) 1 when the external carry-in feeds bit 0 (ADC, SBB)
package addsub_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;  // a + b
    localparam logic [1:0] OP_ADC = 2'b01;  // a + b + cin
    localparam logic [1:0] OP_SUB = 2'b10;  // a + ~b + 1
    localparam logic [1:0] OP_SBB = 2'b11;  // a + ~b + cin

    function automatic logic is_sub(input logic [1:0] op);
        return (op == OP_SUB) || (op == OP_SBB);
    endfunction

    function automatic logic uses_cin(input logic [1:0] op);
        return (op == OP_ADC) || (op == OP_SBB);
    endfunction

endpackage

// File: rtl/addsub_pipe_cla_slice.sv
// Module : cla_slice
// Purpose: Combinational W-bit carry-lookahead adder built from 4-bit groups.
//          Each group forms its own generate/propagate terms and the group
//          carries are chained from group to group.
// Ports  :
//   a, b   in  W  addends
//   ci     in  1  carry into bit 0
//   s      out W  sum
//   co     out 1  carry out of bit W-1
//   c_msb  out 1  carry into bit W-1 (used for signed overflow)
module cla_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb
);

    localparam int NG = W / 4;

    logic [W-1:0] p;
    logic [W-1:0] g;
    logic [W:0]   c;
    logic [NG:0]  gc;   // carry into each 4-bit group

    assign p     = a ^ b;
    assign g     = a & b;
    assign gc[0] = ci;

    generate
        for (genvar gi = 0; gi < NG; gi++) begin : g_group
            logic [3:0] gp;
            logic [3:0] gg;
            logic       grp_p;
            logic       grp_g;

            assign gp = p[gi*4 +: 4];
            assign gg = g[gi*4 +: 4];

            // Group terms let the next group's carry skip this group's
            // internal chain.
            assign grp_p = &gp;
            assign grp_g = gg[3]
                         | (gp[3] & gg[2])
                         | (gp[3] & gp[2] & gg[1])
                         | (gp[3] & gp[2] & gp[1] & gg[0]);
            assign gc[gi+1] = grp_g | (grp_p & gc[gi]);

            // Bit carries inside the group, all expanded from the group carry-in.
            assign c[gi*4]   = gc[gi];
            assign c[gi*4+1] = gg[0] | (gp[0] & gc[gi]);
            assign c[gi*4+2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & gc[gi]);
            assign c[gi*4+3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                             | (gp[2] & gp[1] & gp[0] & gc[gi]);
        end
    endgenerate

    assign c[W]  = gc[NG];
    assign s     = p ^ c[W-1:0];
    assign co    = c[W];
    assign c_msb = c[W-1];

endmodule

// File: rtl/addsub_pipe.sv
// Module : addsub_pipe
// Purpose: Pipelined N-bit adder/subtractor (ADD/ADC/SUB/SBB) with ALU flags.
//          The carry chain is cut into STAGES segments of N/STAGES bits; stage k
//          adds segment k with the carry registered by stage k-1. Upper operand
//          segments travel down the pipe until their stage. A single global
//          advance moves every stage (bubbles included) or freezes them all.
// Ports  :
//   clk, rst_n           clock (rising edge), synchronous active-low reset
//   in_valid / in_ready  operand handshake (op, a, b, cin)
//   out_valid/ out_ready result handshake (s, co, v, z, neg)
//   co   carry out of bit N-1 (subtract: 1 = no borrow)
//   v    signed overflow,  z  s == 0,  neg  s[N-1]
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int N      = 16,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         co,
    output logic         v,
    output logic         z,
    output logic         neg
);

    localparam int SEG = N / STAGES;

    // Index k of the *_p arrays is what stage k consumes; index k+1 is what
    // stage k has registered. Index 0 is the decoded input beat.
    logic [N-1:0] a_p     [STAGES];
    logic [N-1:0] bp_p    [STAGES];
    logic [N-1:0] sum_p   [STAGES+1];
    logic         carry_p [STAGES+1];
    logic         valid_p [STAGES+1];
    logic         cmsb_w  [STAGES];

    logic adv;

    // The last stage's register is the output register, so the whole pipe may
    // move whenever that register is empty or being drained.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign a_p[0]     = a;
    assign bp_p[0]    = is_sub(op) ? ~b : b;
    assign sum_p[0]   = '0;
    assign carry_p[0] = uses_cin(op) ? cin : is_sub(op);
    assign valid_p[0] = in_valid;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [SEG-1:0] seg_s;
            logic           seg_co;
            logic [N-1:0]   sum_next;
            logic           valid_reg;
            logic           carry_reg;
            logic [N-1:0]   sum_reg;

            cla_slice #(.W(SEG)) u_slice (
                .a     (a_p[gi][gi*SEG +: SEG]),
                .b     (bp_p[gi][gi*SEG +: SEG]),
                .ci    (carry_p[gi]),
                .s     (seg_s),
                .co    (seg_co),
                .c_msb (cmsb_w[gi])
            );

            // Lower segments come finished from earlier stages; insert ours.
            always_comb begin
                sum_next                  = sum_p[gi];
                sum_next[gi*SEG +: SEG]   = seg_s;
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    carry_reg <= 1'b0;
                    sum_reg   <= '0;
                end else if (adv) begin
                    valid_reg <= valid_p[gi];
                    carry_reg <= seg_co;
                    sum_reg   <= sum_next;
                end
            end

            assign valid_p[gi+1] = valid_reg;
            assign carry_p[gi+1] = carry_reg;
            assign sum_p[gi+1]   = sum_reg;

            if (gi < STAGES - 1) begin : g_fwd
                // Operands for the segments still to be added.
                logic [N-1:0] a_reg;
                logic [N-1:0] bp_reg;

                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        a_reg  <= '0;
                        bp_reg <= '0;
                    end else if (adv) begin
                        a_reg  <= a_p[gi];
                        bp_reg <= bp_p[gi];
                    end
                end

                assign a_p[gi+1]  = a_reg;
                assign bp_p[gi+1] = bp_reg;
            end else begin : g_flags
                logic v_reg;
                logic z_reg;
                logic neg_reg;

                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        v_reg   <= 1'b0;
                        z_reg   <= 1'b0;
                        neg_reg <= 1'b0;
                    end else if (adv) begin
                        v_reg   <= seg_co ^ cmsb_w[gi];
                        z_reg   <= (sum_next == '0);
                        neg_reg <= sum_next[N-1];
                    end
                end

                assign v   = v_reg;
                assign z   = z_reg;
                assign neg = neg_reg;
            end
        end
    endgenerate

    assign out_valid = valid_p[STAGES];
    assign s         = sum_p[STAGES];
    assign co        = carry_p[STAGES];

endmodule

// File: tb/tb_addsub_pipe.sv
// Testbench for addsub_pipe: directed spec cases plus randomized traffic with
// random valid/ready, checked through a scoreboard queue by a monitor process.
module tb_addsub_pipe;

    localparam int N      = 16;
    localparam int STAGES = 2;

    typedef struct packed {
        logic [N-1:0] s;
        logic         co;
        logic         v;
        logic         z;
        logic         neg;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   op = 2'b00;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] s;
    logic         co;
    logic         v;
    logic         z;
    logic         neg;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   ready_pct = 100;

    always #5 clk = ~clk;

    addsub_pipe #(.N(N), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co),
        .v         (v),
        .z         (z),
        .neg       (neg)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic exp_t mk(input logic [N-1:0] sv, input logic c, input logic ov,
                                input logic zz, input logic ng);
        exp_t e;
        e.s = sv; e.co = c; e.v = ov; e.z = zz; e.neg = ng;
        return e;
    endfunction

    // Reference: plain integer arithmetic, unsigned for sum/carry, signed for overflow.
    function automatic exp_t model(input logic [1:0] o, input logic [N-1:0] av,
                                   input logic [N-1:0] bv, input logic ci);
        exp_t   e;
        longint ua, ub, c, tot, sa, sbv, st;
        longint two_n;
        two_n = longint'(1) << N;
        ua = longint'(av);
        case (o)
            2'b00: begin ub = longint'(bv);  c = 0;  end
            2'b01: begin ub = longint'(bv);  c = longint'(ci); end
            2'b10: begin ub = two_n - 1 - longint'(bv); c = 1; end
            default: begin ub = two_n - 1 - longint'(bv); c = longint'(ci); end
        endcase
        tot   = ua + ub + c;
        e.s   = N'(tot % two_n);
        e.co  = (tot >= two_n);
        sa    = (ua >= two_n / 2) ? ua - two_n : ua;
        sbv   = (ub >= two_n / 2) ? ub - two_n : ub;
        st    = sa + sbv + c;
        e.v   = (st > two_n / 2 - 1) || (st < -(two_n / 2));
        e.z   = (e.s == '0);
        e.neg = e.s[N-1];
        return e;
    endfunction

    function automatic logic pick_ready();
        return ($urandom_range(0, 99) < ready_pct);
    endfunction

    task automatic issue(input logic [1:0] o, input logic [N-1:0] av, input logic [N-1:0] bv,
                         input logic ci, input exp_t e);
        bit done = 0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            out_ready = pick_ready();
            in_valid  = 1'b1;
            op = o; a = av; b = bv; cin = ci;
            #1;
            if (in_ready) begin
                sb.push_back(e);
                $display("issue op=%0d a=0x%0h b=0x%0h cin=%0d -> s=0x%0h", o, av, bv, ci, e.s);
                done = 1;
            end
        end
        if (!done) chk("issue_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            out_ready = pick_ready();
            in_valid  = 1'b0;
            op = 2'($urandom); a = N'($urandom); b = N'($urandom); cin = 1'($urandom);
        end
    endtask

    task automatic drain();
        ready_pct = 100;
        for (int t = 0; t < 100 && sb.size() != 0; t++) idle(1);
        chk("drain_empty", 64'(sb.size()), 64'd0);
        idle(2);
    endtask

    // Monitor: pops the scoreboard whenever a result transfers and checks
    // that a stalled result stays put.
    initial begin : monitor
        exp_t held;
        exp_t e;
        bit   held_v;
        held_v = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                held_v = 0;
            end else if (out_valid) begin
                if (held_v) begin
                    chk("hold_s", 64'(s), 64'(held.s));
                    chk("hold_flags", 64'({co, v, z, neg}), 64'({held.co, held.v, held.z, held.neg}));
                end
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_beat", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        $display("result s=0x%0h co=%0d v=%0d z=%0d neg=%0d", s, co, v, z, neg);
                        chk("s", 64'(s), 64'(e.s));
                        chk("co", 64'(co), 64'(e.co));
                        chk("v", 64'(v), 64'(e.v));
                        chk("z", 64'(z), 64'(e.z));
                        chk("neg", 64'(neg), 64'(e.neg));
                    end
                    held_v = 0;
                end else begin
                    held   = mk(s, co, v, z, neg);
                    held_v = 1;
                end
            end else begin
                if (held_v) chk("hold_valid", 64'(out_valid), 64'd1);
                held_v = 0;
            end
        end
    end

    initial begin : main
        logic [1:0]   o;
        logic [N-1:0] av, bv;
        logic         ci;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_s", 64'(s), 64'd0);
        chk("rst_flags", 64'({co, v, z, neg}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: wrap to zero, and latency
        issue(2'b00, 16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1, 0, 1, 0));
        for (int i = 1; i <= STAGES; i++) begin
            idle(1);
            #1;
            chk("latency_out_valid", 64'(out_valid), (i == STAGES) ? 64'd1 : 64'd0);
        end
        drain();

        // 2, 3: overflow and borrow cases
        issue(2'b00, 16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 0, 1, 0, 1));
        issue(2'b10, 16'h0003, 16'h0005, 1'b0, mk(16'hFFFE, 0, 0, 0, 1));
        issue(2'b10, 16'h8000, 16'h0001, 1'b0, mk(16'h7FFF, 1, 1, 0, 0));
        issue(2'b11, 16'h0005, 16'h0003, 1'b0, mk(16'h0001, 1, 0, 0, 0));
        // 4: 32-bit chain through cin
        issue(2'b00, 16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1, 0, 1, 0));
        issue(2'b01, 16'h0001, 16'h0000, 1'b1, mk(16'h0002, 0, 0, 0, 0));
        drain();

        // 5: backpressure with 4 back-to-back beats
        ready_pct = 0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    av = N'(16'h1111 * (i + 1));
                    bv = N'(16'h0F0F + i);
                    issue(2'b00, av, bv, 1'b0, model(2'b00, av, bv, 1'b0));
                end
            end
            begin
                repeat (4) @(negedge clk);
                #1;
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                chk("bp_out_valid", 64'(out_valid), 64'd1);
                ready_pct = 100;
            end
        join
        drain();

        // 6: reset with a full pipe
        ready_pct = 0;
        issue(2'b00, 16'h1234, 16'h1111, 1'b0, mk(16'h2345, 0, 0, 0, 0));
        issue(2'b10, 16'h5555, 16'h0005, 1'b0, mk(16'h5550, 1, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        ready_pct = 100;
        sb.delete();
        @(negedge clk);
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_s", 64'(s), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        idle(STAGES + 3);

        // Random traffic
        for (int blk = 0; blk < 10; blk++) begin
            ready_pct = (blk % 3 == 0) ? 100 : int'($urandom_range(20, 90));
            for (int i = 0; i < 300; i++) begin
                o  = 2'($urandom);
                av = N'($urandom);
                bv = N'($urandom);
                ci = 1'($urandom);
                if (i % 50 == 0) begin
                    av = '1;
                    bv = (o[1]) ? '1 : N'(1);
                end
                issue(o, av, bv, ci, model(o, av, bv, ci));
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
